w_wb_arbiter: RTL and testbench

Write-back arbiter that drives the single write port of the general register file. It merges two producers: the in-order W-stage write (never stalled) and late results from multi-cycle units (valid/ready). Late results that cannot reach the port immediately are held in a 4-entry FIFO. The block also reports pending writes to the hazard unit.

---
 rtl/w_wb_arbiter_if.sv | 48 ++++
 rtl/w_wb_arbiter.sv | 98 +++++++++
 tb/tb_w_wb_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/w_wb_arbiter_if.sv
// Write-back arbiter bus: W-stage write, late-result handshake, GRF write port,
// hazard queries and FIFO occupancy.
interface w_wb_arbiter_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_addr;
  logic [31:0]   pipe_data;
  logic [31:0]   pipe_pc;

  logic          late_valid;
  logic          late_ready;
  logic [4:0]    late_addr;
  logic [31:0]   late_data;
  logic [31:0]   late_pc;

  logic          grf_we;
  logic [4:0]    grf_A3;
  logic [31:0]   grf_wd;
  logic [31:0]   grf_pc;

  logic [4:0]    pend_addr1;
  logic [4:0]    pend_addr2;
  logic          pend_hit1;
  logic          pend_hit2;

  logic [CW-1:0] count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output late_valid, late_addr, late_data, late_pc,
    input  late_ready,
    input  grf_we, grf_A3, grf_wd, grf_pc,
    output pend_addr1, pend_addr2,
    input  pend_hit1, pend_hit2,
    input  count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  late_valid, late_addr, late_data, late_pc,
    output late_ready,
    output grf_we, grf_A3, grf_wd, grf_pc,
    input  pend_addr1, pend_addr2,
    output pend_hit1, pend_hit2,
    output count
  );
endinterface

// File: rtl/w_wb_arbiter.sv
// GRF write-port arbiter: W-stage writes win, late results wait in a small FIFO,
// and a newer pipe write squashes queued late writes to the same register.
module w_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  w_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t          q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   cnt;

  logic          we_q;
  logic [4:0]    a3_q;
  logic [31:0]   wd_q, pc_q;

  logic          pipe_v, rdy, enq, enq_live, pop;
  logic          h1, h2;

  always_comb begin
    pipe_v   = bus.pipe_we && (bus.pipe_addr != 5'd0);
    rdy      = reset && (cnt < FULL);
    // address-0 late writes complete the handshake but never occupy a slot
    enq      = bus.late_valid && rdy && (bus.late_addr != 5'd0);
    enq_live = !(pipe_v && (bus.late_addr == bus.pipe_addr));
    pop      = !pipe_v && (cnt != '0);
  end

  // Live bits are cleared on pop, so a live entry is always an occupied one.
  always_comb begin
    h1 = we_q && (a3_q == bus.pend_addr1);
    h2 = we_q && (a3_q == bus.pend_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      h1 = h1 || (q[i].live && (q[i].addr == bus.pend_addr1));
      h2 = h2 || (q[i].live && (q[i].addr == bus.pend_addr2));
    end
    h1 = h1 && (bus.pend_addr1 != 5'd0);
    h2 = h2 && (bus.pend_addr2 != 5'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
      pc_q <= '0;
    end else begin
      if (pipe_v) begin
        we_q <= 1'b1;
        a3_q <= bus.pipe_addr;
        wd_q <= bus.pipe_data;
        pc_q <= bus.pipe_pc;
      end else if (pop) begin
        we_q <= q[head].live;
        a3_q <= q[head].addr;
        wd_q <= q[head].data;
        pc_q <= q[head].pc;
      end else begin
        we_q <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++)
        if (pipe_v && (q[i].addr == bus.pipe_addr)) q[i].live <= 1'b0;
      if (pop) q[head].live <= 1'b0;
      // tail slot is free whenever enq is set, so this never collides with the squash above
      if (enq) q[tail] <= '{live: enq_live, addr: bus.late_addr,
                            data: bus.late_data, pc: bus.late_pc};

      head <= head + AW'(pop);
      tail <= tail + AW'(enq);
      cnt  <= cnt + (AW+1)'(enq) - (AW+1)'(pop);
    end
  end

  assign bus.late_ready = rdy;
  assign bus.grf_we     = we_q;
  assign bus.grf_A3     = a3_q;
  assign bus.grf_wd     = wd_q;
  assign bus.grf_pc     = pc_q;
  assign bus.pend_hit1  = h1;
  assign bus.pend_hit2  = h2;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_w_wb_arbiter.sv
// Bench for w_wb_arbiter: directed vector table, reset-in-flight sequence,
// then random traffic checked against a queue model through a scoreboard.
module tb_w_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  w_wb_arbiter_if #(.DEPTH(4)) bus();
  w_wb_arbiter #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  localparam logic [31:0] PPC = 32'hF000_0000;
  localparam logic [31:0] LPC = 32'h0F00_0000;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic pwe; logic [4:0] pa; logic [31:0] pd;
    logic lv;  logic [4:0] la; logic [31:0] ld;
    logic [4:0] qa;
    logic e_rdy; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic [2:0] e_cnt; logic e_hit;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] a3; logic [31:0] wd; logic [31:0] pc; logic [2:0] cnt;
  } exp_t;

  typedef struct {
    logic live; logic [4:0] addr; logic [31:0] data; logic [31:0] pc;
  } ment_t;

  vec_t  tv[$];
  exp_t  sb[$];
  ment_t mq[$];
  logic       m_we = 1'b0;
  logic [4:0] m_a3 = 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic [31:0] ppc, input logic lv, input logic [4:0] la,
                       input logic [31:0] ld, input logic [31:0] lpc,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_data = pd; bus.pipe_pc = ppc;
    bus.late_valid = lv; bus.late_addr = la; bus.late_data = ld; bus.late_pc = lpc;
    bus.pend_addr1 = q1; bus.pend_addr2 = q2;
  endtask

  function automatic vec_t mk(int pwe, int pa, int pd, int lv, int la, int ld, int qa,
                              int rdy, int we, int a3, int wd, int cnt, int hit);
    vec_t v;
    v.pwe = 1'(pwe); v.pa = 5'(pa); v.pd = 32'(pd);
    v.lv = 1'(lv);   v.la = 5'(la); v.ld = 32'(ld);
    v.qa = 5'(qa);
    v.e_rdy = 1'(rdy); v.e_we = 1'(we); v.e_a3 = 5'(a3); v.e_wd = 32'(wd);
    v.e_cnt = 3'(cnt); v.e_hit = 1'(hit);
    return v;
  endfunction

  function automatic logic mhit(input logic [4:0] a);
    logic h;
    h = m_we && (m_a3 == a);
    foreach (mq[i]) if (mq[i].live && (mq[i].addr == a)) h = 1'b1;
    return h && (a != 5'd0);
  endfunction

  initial begin
    vec_t v; exp_t e; ment_t m;
    logic pwe, lv, pv, rdy;
    logic [4:0] pa, la, q1, q2;
    logic [31:0] pd, ld, ppc, lpc, epc;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);

    // pipe write, then idle
    tv.push_back(mk(1, 5, 'h1234, 0, 0, 0,      5, 1, 1, 5, 'h1234, 0, 1));
    tv.push_back(mk(0, 0, 0,      0, 0, 0,      5, 1, 0, 0, 0,      0, 0));
    // single late write through an empty FIFO
    tv.push_back(mk(0, 0, 0,      1, 7, 'hAAAA, 7, 1, 0, 0, 0,      1, 1));
    tv.push_back(mk(0, 0, 0,      0, 0, 0,      7, 1, 1, 7, 'hAAAA, 0, 1));
    tv.push_back(mk(0, 0, 0,      0, 0, 0,      7, 1, 0, 0, 0,      0, 0));
    // fill under continuous pipe writes, 5th held, then drain in order
    tv.push_back(mk(1, 20, 'hC0, 1, 10, 'hB0, 10, 1, 1, 20, 'hC0, 1, 1));
    tv.push_back(mk(1, 21, 'hC1, 1, 11, 'hB1, 10, 1, 1, 21, 'hC1, 2, 1));
    tv.push_back(mk(1, 22, 'hC2, 1, 12, 'hB2, 10, 1, 1, 22, 'hC2, 3, 1));
    tv.push_back(mk(1, 23, 'hC3, 1, 13, 'hB3, 10, 1, 1, 23, 'hC3, 4, 1));
    tv.push_back(mk(1, 24, 'hC4, 1, 14, 'hB4, 10, 0, 1, 24, 'hC4, 4, 1));
    tv.push_back(mk(0, 0, 0,     1, 14, 'hB4, 10, 0, 1, 10, 'hB0, 3, 1));
    tv.push_back(mk(0, 0, 0,     1, 14, 'hB4, 14, 1, 1, 11, 'hB1, 3, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     14, 1, 1, 12, 'hB2, 2, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     14, 1, 1, 13, 'hB3, 1, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     14, 1, 1, 14, 'hB4, 0, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     14, 1, 0, 0, 0,     0, 0));
    // queued late write squashed by a later pipe write
    tv.push_back(mk(0, 0, 0,     1, 9, 1,     9, 1, 0, 0, 0,     1, 1));
    tv.push_back(mk(1, 9, 2,     0, 0, 0,     9, 1, 1, 9, 2,     1, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     9, 1, 0, 0, 0,     0, 0));
    // same-cycle squash of an incoming late write
    tv.push_back(mk(1, 6, 'h66,  1, 6, 'h77,  6, 1, 1, 6, 'h66,  1, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     6, 1, 0, 0, 0,     0, 0));
    // address-0 writes on both sources while the head drains
    tv.push_back(mk(0, 0, 0,     1, 3, 'h33,  3, 1, 0, 0, 0,     1, 1));
    tv.push_back(mk(1, 0, 'hDEAD, 1, 0, 'hBEEF, 3, 1, 1, 3, 'h33, 0, 1));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,     3, 1, 0, 0, 0,     0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset grf_we", 32'(bus.grf_we), 0);
    chk("reset count", 32'(bus.count), 0);
    chk("reset late_ready", 32'(bus.late_ready), 0);
    chk("reset grf_wd", bus.grf_wd, 0);
    @(negedge clk) reset = 1'b1;

    foreach (tv[i]) begin
      v = tv[i];
      @(negedge clk);
      drive(v.pwe, v.pa, v.pd, v.pd ^ PPC, v.lv, v.la, v.ld, v.ld ^ LPC, v.qa, 5'd0);
      #1 chk($sformatf("vec%0d late_ready", i), 32'(bus.late_ready), 32'(v.e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d grf_we", i), 32'(bus.grf_we), 32'(v.e_we));
      if (v.e_we) begin
        epc = (v.pwe && v.pa != 5'd0) ? (v.e_wd ^ PPC) : (v.e_wd ^ LPC);
        chk($sformatf("vec%0d grf_A3", i), 32'(bus.grf_A3), 32'(v.e_a3));
        chk($sformatf("vec%0d grf_wd", i), bus.grf_wd, v.e_wd);
        chk($sformatf("vec%0d grf_pc", i), bus.grf_pc, epc);
      end
      chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(v.e_cnt));
      chk($sformatf("vec%0d pend_hit1", i), 32'(bus.pend_hit1), 32'(v.e_hit));
      chk($sformatf("vec%0d pend_hit2", i), 32'(bus.pend_hit2), 0);
    end

    // reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 5'(20 + k), 32'h500 + k, 32'h600 + k, 1, 5'(15 + k), 32'h700 + k, 32'h800 + k, 15, 0);
    end
    @(posedge clk);
    #1 chk("midrst count before", 32'(bus.count), 3);
    chk("midrst hit before", 32'(bus.pend_hit1), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 15, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst grf_we", 32'(bus.grf_we), 0);
    chk("midrst grf_A3", 32'(bus.grf_A3), 0);
    chk("midrst grf_wd", bus.grf_wd, 0);
    chk("midrst grf_pc", bus.grf_pc, 0);
    chk("midrst count", 32'(bus.count), 0);
    chk("midrst late_ready", 32'(bus.late_ready), 0);
    chk("midrst pend_hit1", 32'(bus.pend_hit1), 0);
    @(negedge clk) reset = 1'b1;
    #1 chk("release late_ready", 32'(bus.late_ready), 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("release%0d grf_we", k), 32'(bus.grf_we), 0);
      chk($sformatf("release%0d count", k), 32'(bus.count), 0);
    end

    // random traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      pwe = ($urandom_range(0, 9) < (((c / 50) % 2) != 0 ? 3 : 8));
      pa  = 5'($urandom_range(0, 7));
      pd  = $urandom; ppc = $urandom;
      lv  = 1'($urandom_range(0, 1));
      la  = 5'($urandom_range(0, 7));
      ld  = $urandom; lpc = $urandom;
      q1  = 5'($urandom_range(0, 7));
      q2  = 5'($urandom_range(0, 7));
      drive(pwe, pa, pd, ppc, lv, la, ld, lpc, q1, q2);

      pv  = pwe && (pa != 5'd0);
      rdy = (mq.size() < 4);
      #1 chk($sformatf("rnd%0d late_ready", c), 32'(bus.late_ready), 32'(rdy));

      e.we = 1'b0; e.a3 = 5'd0; e.wd = 32'd0; e.pc = 32'd0;
      if (pv) foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
      if (pv) begin
        e.we = 1'b1; e.a3 = pa; e.wd = pd; e.pc = ppc;
      end else if (mq.size() > 0) begin
        m = mq.pop_front();
        e.we = m.live; e.a3 = m.addr; e.wd = m.data; e.pc = m.pc;
      end
      if (lv && rdy && la != 5'd0) begin
        m.live = !(pv && la == pa); m.addr = la; m.data = ld; m.pc = lpc;
        mq.push_back(m);
      end
      e.cnt = 3'(mq.size());
      sb.push_back(e);
      m_we = e.we; m_a3 = e.a3;

      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("rnd%0d grf_we", c), 32'(bus.grf_we), 32'(e.we));
      if (e.we) begin
        chk($sformatf("rnd%0d grf_A3", c), 32'(bus.grf_A3), 32'(e.a3));
        chk($sformatf("rnd%0d grf_wd", c), bus.grf_wd, e.wd);
        chk($sformatf("rnd%0d grf_pc", c), bus.grf_pc, e.pc);
      end
      chk($sformatf("rnd%0d count", c), 32'(bus.count), 32'(e.cnt));
      chk($sformatf("rnd%0d pend_hit1", c), 32'(bus.pend_hit1), 32'(mhit(q1)));
      chk($sformatf("rnd%0d pend_hit2", c), 32'(bus.pend_hit2), 32'(mhit(q2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
